// File: rtl/mem_bus_decoder.sv
// Memory-bus decoder/sequencer: control-register block plus NUM_REGIONS wait-stated regions.
// Optional ready-timeout abort is compiled in when MEMBUS_TIMEOUT_EN is defined.
module mem_bus_decoder #(
  parameter int NUM_REGIONS  = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {16'hE000, 16'h4000, 16'h0800, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {16'hE000, 16'hE000, 16'hF800, 16'hF800},
  parameter logic [NUM_REGIONS*4-1:0]          REGION_WAIT = {4'd1, 4'd2, 4'd0, 4'd0},
  parameter logic [NUM_REGIONS-1:0]            REGION_EN   = 4'b1111,
  parameter logic [ADDR_WIDTH-1:0]             CTRL_BASE   = 16'h6000,
  parameter int CTRL_COUNT   = 4,
  parameter int TIMEOUT_BITS = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             cpuAddr,
  input  logic [DATA_WIDTH-1:0]             cpuDataWrite,
  input  logic                              cpuWrite,
  input  logic                              cpuStrobe,
  output logic [DATA_WIDTH-1:0]             cpuDataRead,
  output logic                              cpuReady,
  output logic [NUM_REGIONS-1:0]            regionStrobe,
  output logic                              regionWrite,
  output logic [ADDR_WIDTH-1:0]             regionAddr,
  output logic [DATA_WIDTH-1:0]             regionDataOut,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] regionDataIn,
  input  logic [NUM_REGIONS-1:0]            regionReady,
  output logic [CTRL_COUNT*DATA_WIDTH-1:0]  ctrlOut,
  output logic                              busError,
  output logic [ADDR_WIDTH-1:0]             errorAddr
);

  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int CW = (CTRL_COUNT > 1) ? $clog2(CTRL_COUNT) : 1;
  localparam logic [ADDR_WIDTH-1:0] CTRL_MASK = ADDR_WIDTH'(CTRL_COUNT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] STROBE = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  if (NUM_REGIONS < 1 || NUM_REGIONS > 8 || CTRL_COUNT < 1 || CTRL_COUNT > 16 ||
      (CTRL_COUNT & (CTRL_COUNT - 1)) != 0 || TIMEOUT_BITS < 1) begin : g_bad_cfg
    $error("mem_bus_decoder: unsupported parameter set");
  end

  logic [2:0]            state;
  logic [RW-1:0]         sel_p0;
  logic [3:0]            wait_cnt;
  logic                  ctrl_hit;
  logic [CW-1:0]         ctrl_idx;
  logic [DATA_WIDTH-1:0] ctrl_rd;
  logic                  reg_hit;
  logic [RW-1:0]         hit_idx;
  logic [3:0]            hit_wait;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  timeout;

  // Decode: control block first, then the lowest-index enabled matching region.
  always_comb begin
    ctrl_hit = ((cpuAddr & ~CTRL_MASK) == CTRL_BASE);
    ctrl_idx = cpuAddr[CW-1:0] & CW'(CTRL_COUNT - 1);
    ctrl_rd  = '0;
    for (int k = 0; k < CTRL_COUNT; k++) begin
      if (ctrl_idx == CW'(k)) ctrl_rd = ctrlOut[k*DATA_WIDTH +: DATA_WIDTH];
    end
    reg_hit  = 1'b0;
    hit_idx  = '0;
    hit_wait = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (REGION_EN[i] &&
          ((cpuAddr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        reg_hit  = 1'b1;
        hit_idx  = RW'(i);
        hit_wait = REGION_WAIT[i*4 +: 4];
      end
    end
  end

  always_comb begin
    sel_ready    = 1'b0;
    sel_data     = '0;
    regionStrobe = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_p0 == RW'(i)) begin
        sel_ready       = regionReady[i];
        sel_data        = regionDataIn[i*DATA_WIDTH +: DATA_WIDTH];
        regionStrobe[i] = (state == STROBE);
      end
    end
  end

  assign cpuReady = (state == DONE);
  assign busError = (state == ERR);

`ifdef MEMBUS_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] to_cnt;
  logic                    stalled;

  assign stalled = (state == WAIT) && (wait_cnt == 4'd0) && !sel_ready;
  assign timeout = stalled && (to_cnt == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       to_cnt <= '0;
    else if (stalled) to_cnt <= to_cnt + 1'b1;
    else              to_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sel_p0        <= '0;
      wait_cnt      <= '0;
      regionAddr    <= '0;
      regionDataOut <= '0;
      regionWrite   <= 1'b0;
      cpuDataRead   <= '0;
      errorAddr     <= '0;
      ctrlOut       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpuStrobe) begin
            regionAddr    <= cpuAddr;
            regionDataOut <= cpuDataWrite;
            regionWrite   <= cpuWrite;
            cpuDataRead   <= '0;
            if (ctrl_hit) begin
              if (cpuWrite) begin
                for (int k = 0; k < CTRL_COUNT; k++) begin
                  if (ctrl_idx == CW'(k)) ctrlOut[k*DATA_WIDTH +: DATA_WIDTH] <= cpuDataWrite;
                end
              end else begin
                cpuDataRead <= ctrl_rd;
              end
              state <= DONE;
            end else if (reg_hit) begin
              sel_p0   <= hit_idx;
              wait_cnt <= hit_wait;
              state    <= STROBE;
            end else begin
              errorAddr <= cpuAddr;
              state     <= ERR;
            end
          end
        end
        STROBE: state <= WAIT;
        WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (sel_ready) begin
            cpuDataRead <= regionWrite ? '0 : sel_data;
            state       <= DONE;
          end else if (timeout) begin
            errorAddr   <= regionAddr;
            cpuDataRead <= '0;
            state       <= ERR;
          end
        end
        ERR:     state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
